// File: rtl/full_subtractor_df.sv
// 1-bit dataflow full subtractor (A - B - Bin) with a registered result copy
// and a saturating count of clock edges that saw a borrow-out.
module full_subtractor_df #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A,
    input  logic             B,
    input  logic             Bin,
    output logic             Diff,
    output logic             Bout,
    output logic             Diff_q,
    output logic             Bout_q,
    output logic [CNT_W-1:0] borrow_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Zero-latency outputs for the ripple-borrow chain.
    assign Diff = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

    // Registered view; reset takes priority over counting on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            Diff_q     <= 1'b0;
            Bout_q     <= 1'b0;
            borrow_cnt <= '0;
        end else begin
            Diff_q <= Diff;
            Bout_q <= Bout;
            if (Bout && (borrow_cnt != CNT_MAX)) begin
                borrow_cnt <= borrow_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_full_subtractor_df.sv
// Directed bench for full_subtractor_df: truth table, reset, latency,
// counting, saturation (3-bit instance) and reset priority.
module tb_full_subtractor_df;

    logic       clk = 1'b0;
    logic       run = 1'b0;
    logic       rst = 1'b0;
    logic       A = 1'b0, B = 1'b0, Bin = 1'b0;
    logic       diff, bout, diff_q, bout_q;
    logic [7:0] cnt;
    logic       diff_s, bout_s, diff_q_s, bout_q_s;
    logic [2:0] cnt_s;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    full_subtractor_df #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .Bin(Bin),
        .Diff(diff), .Bout(bout), .Diff_q(diff_q), .Bout_q(bout_q),
        .borrow_cnt(cnt)
    );

    full_subtractor_df #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .A(A), .B(B), .Bin(Bin),
        .Diff(diff_s), .Bout(bout_s), .Diff_q(diff_q_s), .Bout_q(bout_q_s),
        .borrow_cnt(cnt_s)
    );

    always begin
        #5;
        if (run) clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] v);
        {A, B, Bin} = v;
    endtask

    initial begin
        logic [7:0] diff_tab;
        logic [7:0] bout_tab;
        diff_tab = 8'b1001_0110;  // index {A,B,Bin}
        bout_tab = 8'b1000_1110;

        // Combinational sweep with the clock idle
        for (int i = 0; i < 8; i++) begin
            drive(3'(i));
            #10;
            check($sformatf("diff_%03b", 3'(i)), 32'(diff), 32'(diff_tab[i]));
            check($sformatf("bout_%03b", 3'(i)), 32'(bout), 32'(bout_tab[i]));
            check($sformatf("ident_%03b", 3'(i)),
                  32'(int'(A) - int'(B) - int'(Bin)),
                  32'(int'(diff) - 2 * int'(bout)));
        end

        // Reset for two edges with 010 applied
        run = 1'b1;
        rst = 1'b1;
        drive(3'b010);
        tick();
        tick();
        check("rst_diff_q", 32'(diff_q), 32'd0);
        check("rst_bout_q", 32'(bout_q), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_cnt_s", 32'(cnt_s), 32'd0);
        check("rst_diff_comb", 32'(diff), 32'd1);
        check("rst_bout_comb", 32'(bout), 32'd1);

        // Latency: 011 applied between edges, visible only after the next edge
        rst = 1'b0;
        drive(3'b011);
        #2;
        check("lat_pre_diff_q", 32'(diff_q), 32'd0);
        check("lat_pre_bout_q", 32'(bout_q), 32'd0);
        tick();
        check("lat_diff_q", 32'(diff_q), 32'd0);
        check("lat_bout_q", 32'(bout_q), 32'd1);
        check("lat_cnt", 32'(cnt), 32'd1);

        // Counter: 5 edges of 010 then 3 edges of 100
        rst = 1'b1;
        drive(3'b100);
        tick();
        check("cnt_clear", 32'(cnt), 32'd0);
        rst = 1'b0;
        drive(3'b010);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("cnt_inc_%0d", i), 32'(cnt), 32'(i));
        end
        drive(3'b100);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("cnt_hold_%0d", i), 32'(cnt), 32'd5);
            check($sformatf("cnt_hold_s_%0d", i), 32'(cnt_s), 32'd5);
        end
        check("hold_diff_q", 32'(diff_q), 32'd1);
        check("hold_bout_q", 32'(bout_q), 32'd0);

        // Saturation of the 3-bit counter while the 8-bit one keeps counting
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(3'b111);
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("sat_s_%0d", i), 32'(cnt_s), 32'((i > 7) ? 7 : i));
            check($sformatf("sat_w_%0d", i), 32'(cnt), 32'(i));
        end
        check("sat_diff_q", 32'(diff_q_s), 32'd1);
        check("sat_bout_q", 32'(bout_q_s), 32'd1);

        // Reset mid-count: reset beats increment, then counting resumes from 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(3'b010);
        for (int i = 1; i <= 4; i++) tick();
        check("mid_cnt4", 32'(cnt), 32'd4);
        check("mid_cnt4_s", 32'(cnt_s), 32'd4);
        rst = 1'b1;
        #2;
        check("mid_async_none", 32'(cnt), 32'd4);
        tick();
        check("mid_rst_cnt", 32'(cnt), 32'd0);
        check("mid_rst_cnt_s", 32'(cnt_s), 32'd0);
        check("mid_rst_bout_q", 32'(bout_q), 32'd0);
        check("mid_rst_bout", 32'(bout), 32'd1);
        rst = 1'b0;
        tick();
        check("mid_resume", 32'(cnt), 32'd1);
        check("mid_resume_bout_q", 32'(bout_q), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
